// File: rtl/bus_responder.sv
// Memory-mapped bus responder: byte RAM, a 16-bit timer with a latched high byte,
// and a 4-entry output FIFO, all behind a single registered read port.
module bus_responder #(
  parameter int          RAM_AW  = 9,
  parameter logic [15:0] IO_BASE = 16'hD000
) (
  input  logic        CLK,
  input  logic        R,
  input  logic [15:0] ADDR,
  input  logic        WE,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic [7:0]  mem [RAM_DEPTH];
  logic [7:0]  fifo_mem [4];
  logic [15:0] counter;
  logic [7:0]  hi_shadow;
  logic        ten;
  logic [1:0]  head;
  logic [1:0]  tail;
  logic [2:0]  count;
  logic        ovf;

  logic       in_ram;
  logic       in_io;
  logic       sel_tlo;
  logic       sel_thi;
  logic       sel_stat;
  logic       sel_fifo;
  logic       sel_ctrl;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push_req;
  logic       push;
  logic       overflow;
  logic [7:0] rd_data;

  assign in_ram   = (ADDR >> RAM_AW) == 16'd0;
  assign in_io    = ADDR[15:3] == IO_BASE[15:3];
  assign sel_tlo  = in_io && ADDR[2:0] == 3'd0;
  assign sel_thi  = in_io && ADDR[2:0] == 3'd1;
  assign sel_stat = in_io && ADDR[2:0] == 3'd2;
  assign sel_fifo = in_io && ADDR[2:0] == 3'd3;
  assign sel_ctrl = in_io && ADDR[2:0] == 3'd4;

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign full     = count == 3'd4;
  assign empty    = count == 3'd0;
  assign pop      = !empty && OUT_READY;
  assign push_req = WE && sel_fifo;
  assign push     = push_req && (!full || pop);
  assign overflow = push_req && full && !pop;

  assign OUT_VALID = !empty;
  assign OUT_DATA  = empty ? 8'h00 : fifo_mem[head];

  always_comb begin
    rd_data = 8'hFF;
    if (in_ram) begin
      rd_data = mem[ADDR[RAM_AW-1:0]];
    end else if (sel_tlo) begin
      rd_data = counter[7:0];
    end else if (sel_thi) begin
      rd_data = hi_shadow;
    end else if (sel_stat) begin
      rd_data = {5'b0, ovf, full, empty};
    end else if (sel_fifo) begin
      rd_data = 8'h00;
    end else if (sel_ctrl) begin
      rd_data = {7'b0, ten};
    end
  end

  // RAM and FIFO storage carry no reset; RAM must survive reset and FIFO slots are masked by count.
  always_ff @(posedge CLK) begin
    if (WE && in_ram) mem[ADDR[RAM_AW-1:0]] <= DIN;
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[tail] <= DIN;
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      DOUT      <= 8'h00;
      counter   <= 16'h0000;
      hi_shadow <= 8'h00;
      ten       <= 1'b0;
      head      <= 2'd0;
      tail      <= 2'd0;
      count     <= 3'd0;
      ovf       <= 1'b0;
    end else begin
      DOUT <= rd_data;
      if (sel_tlo) hi_shadow <= counter[15:8];

      // Clear beats increment; the increment uses the enable held before this edge.
      if (WE && sel_ctrl && DIN[1]) counter <= 16'h0000;
      else if (ten)                 counter <= counter + 16'd1;
      if (WE && sel_ctrl) ten <= DIN[0];

      if (pop)  head <= head + 2'd1;
      if (push) tail <= tail + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      if (overflow)      ovf <= 1'b1;
      else if (sel_stat) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Randomized self-checking bench for bus_responder against a per-edge behavioural model
// (byte array for RAM, integer timer, queue for the FIFO).
module tb_bus_responder;

  localparam logic [15:0] TLO  = 16'hD000;
  localparam logic [15:0] THI  = 16'hD001;
  localparam logic [15:0] STAT = 16'hD002;
  localparam logic [15:0] FWR  = 16'hD003;
  localparam logic [15:0] CTRL = 16'hD004;
  localparam logic [15:0] RAMA = 16'h0010;

  logic        CLK = 1'b0;
  logic        R = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic        WE = 1'b0;
  logic [7:0]  DIN = 8'h00;
  logic        OUT_READY = 1'b0;
  logic [7:0]  DOUT;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;

  int n_checks = 0;
  int n_errors = 0;

  bus_responder #(.RAM_AW(9), .IO_BASE(16'hD000)) dut (
    .CLK(CLK), .R(R), .ADDR(ADDR), .WE(WE), .DIN(DIN), .DOUT(DOUT),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  logic [7:0] m_ram [512];
  bit         m_wr [512];
  int         m_cnt = 0;
  bit         m_ten = 1'b0;
  logic [7:0] m_shadow = 8'h00;
  logic [7:0] m_q [$];
  bit         m_ovf = 1'b0;
  logic [7:0] m_dout = 8'h00;
  bit         m_known = 1'b1;

  // Returns {defined, byte} for what a read of address a yields in the current model state.
  function automatic logic [8:0] m_read(input logic [15:0] a);
    if (a < 16'h0200) return m_wr[a[8:0]] ? {1'b1, m_ram[a[8:0]]} : 9'h000;
    case (a)
      TLO:     return {1'b1, 8'(m_cnt % 256)};
      THI:     return {1'b1, m_shadow};
      STAT:    return {1'b1, 5'b0, m_ovf, m_q.size() == 4, m_q.size() == 0};
      FWR:     return 9'h100;
      CTRL:    return {1'b1, 7'b0, m_ten};
      default: return 9'h1FF;
    endcase
  endfunction

  task automatic model_edge(input logic [15:0] a, input bit w, input logic [7:0] d, input bit rdy);
    logic [8:0] r;
    bit full, pop, push_req, ovf_now;
    r        = m_read(a);
    full     = m_q.size() == 4;
    pop      = m_q.size() > 0 && rdy;
    push_req = w && a == FWR;
    ovf_now  = push_req && full && !pop;
    m_dout   = r[7:0];
    m_known  = r[8];
    if (a == TLO) m_shadow = 8'(m_cnt / 256);
    if (w && a < 16'h0200) begin
      m_ram[a[8:0]] = d;
      m_wr[a[8:0]]  = 1'b1;
    end
    if (w && a == CTRL && d[1]) m_cnt = 0;
    else if (m_ten)             m_cnt = (m_cnt + 1) % 65536;
    if (w && a == CTRL) m_ten = d[0];
    if (pop) void'(m_q.pop_front());
    if (push_req && !ovf_now) m_q.push_back(d);
    if (ovf_now)        m_ovf = 1'b1;
    else if (a == STAT) m_ovf = 1'b0;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ten = 1'b0; m_shadow = 8'h00; m_q.delete(); m_ovf = 1'b0;
    m_dout = 8'h00; m_known = 1'b1;
  endtask

  // One bus cycle: drive, let the edge happen, advance the model, settle 1 ns.
  task automatic apply_stimulus(input logic [15:0] a, input bit w, input logic [7:0] d, input bit rdy);
    ADDR = a; WE = w; DIN = d; OUT_READY = rdy;
    @(posedge CLK);
    model_edge(a, w, d, rdy);
    #1;
  endtask

  task automatic drain();
    repeat (5) apply_stimulus(RAMA, 1'b0, 8'h00, 1'b1);
    apply_stimulus(STAT, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (DOUT !== 8'h00) begin n_errors++; $display("[TB] FAIL reset_dout: got %h expected 00", DOUT); end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_valid: got %b expected 0", OUT_VALID); end
    n_checks++; if (OUT_DATA !== 8'h00) begin n_errors++; $display("[TB] FAIL reset_data: got %h expected 00", OUT_DATA); end
    ADDR = FWR; WE = 1'b1; DIN = 8'h77;
    @(posedge CLK); #1;
    n_checks++; if (OUT_VALID !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_push_blocked: got %b expected 0", OUT_VALID); end
    WE = 1'b0; ADDR = RAMA;
    #2 R = 1'b1;
    model_reset();
    apply_stimulus(STAT, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h01) begin n_errors++; $display("[TB] FAIL reset_status: got %h expected 01", DOUT); end
    apply_stimulus(TLO, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h00) begin n_errors++; $display("[TB] FAIL reset_timer: got %h expected 00", DOUT); end
    apply_stimulus(CTRL, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h00) begin n_errors++; $display("[TB] FAIL reset_ctrl: got %h expected 00", DOUT); end
  endtask

  task automatic test_ram_basic();
    apply_stimulus(RAMA, 1'b1, 8'hA5, 1'b0);
    apply_stimulus(RAMA, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'hA5) begin n_errors++; $display("[TB] FAIL ram_readback: got %h expected a5", DOUT); end
    apply_stimulus(16'h0200, 1'b1, 8'h12, 1'b0);
    n_checks++; if (DOUT !== 8'hFF) begin n_errors++; $display("[TB] FAIL unmapped_0200: got %h expected ff", DOUT); end
    apply_stimulus(16'h0011, 1'b1, 8'h3C, 1'b0);
    apply_stimulus(16'h0011, 1'b1, 8'h5A, 1'b0);
    n_checks++; if (DOUT !== 8'h3C) begin n_errors++; $display("[TB] FAIL ram_prewrite: got %h expected 3c", DOUT); end
    apply_stimulus(16'h0011, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h5A) begin n_errors++; $display("[TB] FAIL ram_second_write: got %h expected 5a", DOUT); end
  endtask

  task automatic test_ram_random();
    int wq[$];
    logic [15:0] a;
    bit w;
    for (int i = 0; i < 80; i++) begin
      w = 1'b0;
      case ($urandom % 3)
        0: begin
          a = 16'($urandom_range(16'h0020, 16'h01FF));
          w = 1'b1;
          wq.push_back(int'(a));
        end
        1: a = (wq.size() > 0) ? 16'(wq[$urandom_range(0, wq.size() - 1)]) : RAMA;
        default: begin
          w = 1'($urandom % 2);
          case ($urandom % 3)
            0:       a = 16'(16'h0200 + $urandom_range(0, 16'hCDFF));
            1:       a = 16'(16'hD005 + $urandom_range(0, 2));
            default: a = 16'(16'hD008 + $urandom_range(0, 16'h2FF7));
          endcase
        end
      endcase
      apply_stimulus(a, w, 8'($urandom), 1'b0);
      if (m_known) begin
        n_checks++;
        if (DOUT !== m_dout) begin
          n_errors++; $display("[TB] FAIL ram_random @%h: got %h expected %h", a, DOUT, m_dout);
        end
      end
    end
  endtask

  task automatic test_timer();
    logic [7:0] lo_exp;
    apply_stimulus(CTRL, 1'b1, 8'h01, 1'b0);
    repeat (300) apply_stimulus(RAMA, 1'b0, 8'h00, 1'b0);
    apply_stimulus(TLO, 1'b1, 8'h77, 1'b0);
    lo_exp = m_dout;
    n_checks++; if (DOUT !== lo_exp) begin n_errors++; $display("[TB] FAIL timer_lo: got %h expected %h", DOUT, lo_exp); end
    apply_stimulus(THI, 1'b1, 8'h88, 1'b0);
    n_checks++; if (DOUT !== m_dout) begin n_errors++; $display("[TB] FAIL timer_hi_shadow: got %h expected %h", DOUT, m_dout); end
    apply_stimulus(CTRL, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h01) begin n_errors++; $display("[TB] FAIL ctrl_read: got %h expected 01", DOUT); end
    apply_stimulus(CTRL, 1'b1, 8'h03, 1'b0);
    apply_stimulus(TLO, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h00) begin n_errors++; $display("[TB] FAIL timer_clear: got %h expected 00", DOUT); end
    apply_stimulus(TLO, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h01) begin n_errors++; $display("[TB] FAIL timer_resume: got %h expected 01", DOUT); end
    apply_stimulus(CTRL, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h01) begin n_errors++; $display("[TB] FAIL ctrl_clear_bit: got %h expected 01", DOUT); end
  endtask

  task automatic test_wrap();
    apply_stimulus(CTRL, 1'b1, 8'h03, 1'b0);
    repeat (65535) apply_stimulus(RAMA, 1'b0, 8'h00, 1'b0);
    apply_stimulus(TLO, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'hFF) begin n_errors++; $display("[TB] FAIL wrap_lo_ffff: got %h expected ff", DOUT); end
    apply_stimulus(THI, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'hFF) begin n_errors++; $display("[TB] FAIL wrap_hi_ffff: got %h expected ff", DOUT); end
    apply_stimulus(TLO, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h01) begin n_errors++; $display("[TB] FAIL wrap_lo_after: got %h expected 01", DOUT); end
    apply_stimulus(THI, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h00) begin n_errors++; $display("[TB] FAIL wrap_hi_after: got %h expected 00", DOUT); end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain();
    for (int i = 1; i <= 5; i++) apply_stimulus(FWR, 1'b1, 8'(i * 8'h11), 1'b0);
    apply_stimulus(STAT, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h06) begin n_errors++; $display("[TB] FAIL status_ovf_full: got %h expected 06", DOUT); end
    apply_stimulus(STAT, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h02) begin n_errors++; $display("[TB] FAIL status_ovf_cleared: got %h expected 02", DOUT); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_seq[i]) begin
        n_errors++; $display("[TB] FAIL fifo_order[%0d]: got v=%b d=%h expected v=1 d=%h", i, OUT_VALID, OUT_DATA, exp_seq[i]);
      end
      apply_stimulus(RAMA, 1'b0, 8'h00, 1'b1);
    end
    n_checks++; if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'h00) begin n_errors++; $display("[TB] FAIL fifo_empty: got v=%b d=%h expected v=0 d=00", OUT_VALID, OUT_DATA); end
    apply_stimulus(STAT, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h01) begin n_errors++; $display("[TB] FAIL status_empty: got %h expected 01", DOUT); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h22, 8'h33, 8'h44, 8'h66};
    drain();
    for (int i = 1; i <= 4; i++) apply_stimulus(FWR, 1'b1, 8'(i * 8'h11), 1'b0);
    apply_stimulus(FWR, 1'b1, 8'h66, 1'b1);
    n_checks++; if (OUT_DATA !== 8'h22) begin n_errors++; $display("[TB] FAIL full_pushpop_head: got %h expected 22", OUT_DATA); end
    apply_stimulus(STAT, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h02) begin n_errors++; $display("[TB] FAIL full_pushpop_status: got %h expected 02", DOUT); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_seq[i]) begin
        n_errors++; $display("[TB] FAIL pushpop_order[%0d]: got v=%b d=%h expected v=1 d=%h", i, OUT_VALID, OUT_DATA, exp_seq[i]);
      end
      apply_stimulus(RAMA, 1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_fifo_random();
    logic [15:0] a;
    bit w;
    logic [7:0] exp_data;
    for (int i = 0; i < 250; i++) begin
      w = 1'b0;
      case ($urandom % 4)
        0, 1: begin a = FWR; w = ($urandom % 4) != 0; end
        2:    a = STAT;
        default: a = RAMA;
      endcase
      apply_stimulus(a, w, 8'($urandom), 1'($urandom % 2));
      exp_data = (m_q.size() > 0) ? m_q[0] : 8'h00;
      n_checks++;
      if (OUT_VALID !== (m_q.size() > 0) || OUT_DATA !== exp_data) begin
        n_errors++; $display("[TB] FAIL fifo_random[%0d]: got v=%b d=%h expected v=%b d=%h", i, OUT_VALID, OUT_DATA, m_q.size() > 0, exp_data);
      end
      n_checks++;
      if (DOUT !== m_dout) begin
        n_errors++; $display("[TB] FAIL fifo_random_dout[%0d]: got %h expected %h", i, DOUT, m_dout);
      end
    end
  endtask

  task automatic test_reset_midop();
    drain();
    apply_stimulus(CTRL, 1'b1, 8'h01, 1'b0);
    for (int i = 1; i <= 3; i++) apply_stimulus(FWR, 1'b1, 8'(8'hA0 + i), 1'b0);
    apply_stimulus(STAT, 1'b0, 8'h00, 1'b0);
    n_checks++; if (OUT_VALID !== 1'b1 || DOUT !== 8'h00) begin n_errors++; $display("[TB] FAIL midop_before: got v=%b dout=%h expected v=1 dout=00", OUT_VALID, DOUT); end
    apply_stimulus(TLO, 1'b0, 8'h00, 1'b0);
    #2 R = 1'b0;
    #1;
    n_checks++; if (OUT_VALID !== 1'b0) begin n_errors++; $display("[TB] FAIL midop_valid: got %b expected 0", OUT_VALID); end
    n_checks++; if (DOUT !== 8'h00) begin n_errors++; $display("[TB] FAIL midop_dout: got %h expected 00", DOUT); end
    n_checks++; if (OUT_DATA !== 8'h00) begin n_errors++; $display("[TB] FAIL midop_data: got %h expected 00", OUT_DATA); end
    model_reset();
    #2 R = 1'b1;
    apply_stimulus(RAMA, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'hA5) begin n_errors++; $display("[TB] FAIL midop_ram_kept: got %h expected a5", DOUT); end
    apply_stimulus(TLO, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h00) begin n_errors++; $display("[TB] FAIL midop_timer: got %h expected 00", DOUT); end
    apply_stimulus(THI, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h00) begin n_errors++; $display("[TB] FAIL midop_shadow: got %h expected 00", DOUT); end
    apply_stimulus(STAT, 1'b0, 8'h00, 1'b0);
    n_checks++; if (DOUT !== 8'h01) begin n_errors++; $display("[TB] FAIL midop_status: got %h expected 01", DOUT); end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_ram_basic();
    test_ram_random();
    test_timer();
    test_wrap();
    test_fifo_overflow();
    test_back_to_back();
    test_fifo_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter RAM_AW, default 9, RAM address width; RAM occupies 0x0000 to (2^RAM_AW)-1.
REQ-002 Parameter IO_BASE, default 16'hD000, base address of the 8-byte I/O register window.
REQ-003 CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 R  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-005 ADDR  input  16  CPU address bus.
REQ-006 WE  input  1  write enable from CPU; 1 = write DIN at ADDR on this edge.
REQ-007 DIN  input  8  write data from CPU.
REQ-008 DOUT  output  8  registered read data to CPU.
REQ-009 OUT_DATA  output  8  head entry of output FIFO.
REQ-010 OUT_VALID  output  1  1 = OUT_DATA holds a valid entry.
REQ-011 OUT_READY  input  1  downstream consumer accepts OUT_DATA when 1 with OUT_VALID.

Function
REQ-012 Read latency SHALL be one cycle: DOUT updates on each rising edge from ADDR sampled at that edge and holds between edges.
REQ-013 Reads SHALL occur every cycle regardless of WE; on a write cycle DOUT SHALL return the pre-write contents of the addressed location.
REQ-014 RAM region: write stores DIN; read returns stored byte; RAM contents SHALL NOT be cleared by reset.
REQ-015 I/O map (offset from IO_BASE): +0 TMR_LO, +1 TMR_HI, +2 STATUS, +3 FIFO_WR, +4 CTRL; +5..+7 reserved.
REQ-016 Unmapped and reserved addresses SHALL read 0xFF; writes to them SHALL be ignored.
REQ-017 Timer: 16-bit counter, increments by 1 each cycle while CTRL.bit0 (TEN) = 1; wraps 0xFFFF -> 0x0000.
REQ-018 Reading TMR_LO SHALL return counter[7:0] at the sampling edge and copy counter[15:8] into a HI shadow register in the same edge.
REQ-019 Reading TMR_HI SHALL return the HI shadow, not the live counter.
REQ-020 Writes to TMR_LO/TMR_HI SHALL be ignored.
REQ-021 CTRL write: bit0 -> TEN; bit1 = 1 clears counter to 0x0000 at that edge (clear overrides increment); bit1 self-clears and reads 0; CTRL read = {7'b0, TEN}.
REQ-022 Output FIFO: 4 entries, 8 bits, 2-bit pointers wrapping 3 -> 0, 3-bit occupancy count 0..4.
REQ-023 Write to FIFO_WR with FIFO not full SHALL push DIN at tail; FIFO_WR reads 0x00.
REQ-024 OUT_VALID = (count != 0); OUT_DATA = head entry (0x00 when empty); pop when OUT_VALID && OUT_READY at the edge.
REQ-025 Simultaneous push and pop SHALL both occur, count unchanged, including when full (no overflow).
REQ-026 Push when full without simultaneous pop SHALL be dropped and set sticky OVF.
REQ-027 STATUS read = {5'b0, OVF, full, empty} sampled before the edge; reading STATUS clears OVF at that edge, unless an overflow occurs the same edge (set wins).

Reset
REQ-028 While R = 0: DOUT = 0x00, counter = 0x0000, HI shadow = 0x00, TEN = 0, FIFO pointers and count = 0, OVF = 0, OUT_VALID = 0, OUT_DATA = 0x00.
REQ-029 Reset asserted mid-operation SHALL discard FIFO contents immediately; RAM contents SHALL be retained.
REQ-030 First state update after R deasserts SHALL be on the next rising CLK edge.

Verification
REQ-031 Write 0xA5 to 0x0010, then read 0x0010 -> DOUT = 0xA5 one cycle after read address presented; read 0x0200 (RAM_AW = 9) -> 0xFF.
REQ-032 CTRL <- 0x01, run 300 cycles, read TMR_LO then TMR_HI -> HI shadow equals counter[15:8] at TMR_LO read, not incremented value; CTRL <- 0x03 -> counter 0x0000 next cycle, then resumes counting.
REQ-033 Preload counter near wrap (enable 65534 cycles after clear) -> counter passes 0xFFFF -> 0x0000.
REQ-034 OUT_READY = 0, push 0x11,0x22,0x33,0x44,0x55 -> STATUS = 0x06 (OVF, full); STATUS re-read -> 0x02; OUT_READY = 1 -> OUT_DATA sequence 0x11,0x22,0x33,0x44, then OUT_VALID = 0, STATUS = 0x01.
REQ-035 FIFO full, push 0x66 with OUT_READY = 1 same edge -> 0x11 popped, 0x66 enqueued, OVF stays 0, count stays 4.
REQ-036 Assert R = 0 with 3 FIFO entries and TEN = 1 between edges -> OUT_VALID = 0 and DOUT = 0x00 immediately; after release, RAM byte at 0x0010 still reads 0xA5.
